// File: rtl/immediate_sequencer.sv
// Immediate sequencer: latches an instruction word, drives the immediate block's extend
// mode for a settle window, then captures and delivers the 32-bit immediate.
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | waiting for a word, Extend = 0
// SETTLE      | Extend held for IMM_SETTLE cycles, then capture into Imm_Out
// WIDE_SETTLE | first word of a wide immediate settling, then store upper half
// WIDE_WAIT   | upper half stored, waiting for the second (lower) word
// OUT         | Imm_Valid high until the consumer takes it
module immediate_sequencer #(
    parameter logic [5:0]  OPC_ANDI   = 6'h0C,
    parameter logic [5:0]  OPC_ORI    = 6'h0D,
    parameter logic [5:0]  OPC_WIDE   = 6'h0F,
    parameter int unsigned IMM_SETTLE = 1
) (
    input  logic        clk,
    input  logic        Reset_n,
    input  logic        IR_Valid,
    input  logic [31:0] IR,
    output logic        IR_Ready,
    output logic [31:0] IR_Hold,
    output logic [1:0]  Extend,
    input  logic [31:0] Imm_In,
    output logic [31:0] Imm_Out,
    output logic        Imm_Valid,
    input  logic        Imm_Ready,
    input  logic        Abort,
    output logic        Busy
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SETTLE      = 3'd1,
        WIDE_WAIT   = 3'd2,
        WIDE_SETTLE = 3'd3,
        OUT         = 3'd4
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(IMM_SETTLE - 1);

    state_t      state;
    logic [2:0]  cnt;
    logic [15:0] upper;
    logic        wide;
    logic        accept;
    logic [5:0]  opc;
    logic        zext;

    assign accept = IR_Valid & IR_Ready & ~Abort;
    assign opc    = IR[31:26];
    assign zext   = (opc == OPC_ANDI) || (opc == OPC_ORI) || (opc == OPC_WIDE);
    assign Busy   = (state != IDLE);

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            upper     <= 16'd0;
            wide      <= 1'b0;
            IR_Ready  <= 1'b0;
            IR_Hold   <= 32'd0;
            Extend    <= 2'd0;
            Imm_Out   <= 32'd0;
            Imm_Valid <= 1'b0;
        end else if (Abort) begin
            // Flush wins over any accept or handshake offered in the same cycle.
            state     <= IDLE;
            cnt       <= 3'd0;
            upper     <= 16'd0;
            wide      <= 1'b0;
            IR_Ready  <= 1'b1;
            Extend    <= 2'd0;
            Imm_Valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        IR_Hold  <= IR;
                        Extend   <= zext ? 2'd2 : 2'd1;
                        cnt      <= CNT_LOAD;
                        IR_Ready <= 1'b0;
                        if (opc == OPC_WIDE) begin
                            state <= WIDE_SETTLE;
                            wide  <= 1'b1;
                        end else begin
                            state <= SETTLE;
                        end
                    end else begin
                        IR_Ready <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == 3'd0) begin
                        Imm_Out   <= wide ? {upper, Imm_In[15:0]} : Imm_In;
                        Imm_Valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                WIDE_SETTLE: begin
                    if (cnt == 3'd0) begin
                        upper    <= Imm_In[15:0];
                        IR_Ready <= 1'b1;
                        state    <= WIDE_WAIT;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                WIDE_WAIT: begin
                    // Lower half of a wide immediate is always zero-extended.
                    if (accept) begin
                        IR_Hold  <= IR;
                        Extend   <= 2'd2;
                        cnt      <= CNT_LOAD;
                        IR_Ready <= 1'b0;
                        state    <= SETTLE;
                    end
                end
                OUT: begin
                    if (Imm_Ready) begin
                        Imm_Valid <= 1'b0;
                        Extend    <= 2'd0;
                        wide      <= 1'b0;
                        IR_Ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    Extend   <= 2'd0;
                    IR_Ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_immediate_sequencer.sv
// Directed bench for immediate_sequencer: two instances (IMM_SETTLE 1 and 3) share stimulus,
// each fed by its own model of the sign/zero immediate block.
module tb_immediate_sequencer;

    logic        clk;
    logic        Reset_n;
    logic        IR_Valid;
    logic [31:0] IR;
    logic        Imm_Ready;
    logic        Abort;

    logic        ir_ready1, imm_valid1, busy1;
    logic [31:0] ir_hold1, imm_in1, imm_out1;
    logic [1:0]  extend1;
    logic        ir_ready3, imm_valid3, busy3;
    logic [31:0] ir_hold3, imm_in3, imm_out3;
    logic [1:0]  extend3;

    int tests_run;
    int tests_failed;

    function automatic logic [31:0] ext_model(logic [31:0] h, logic [1:0] e);
        logic [15:0] f;
        f = h[21:6];
        if (e == 2'd1) return {{16{f[15]}}, f};
        if (e == 2'd2) return {16'h0000, f};
        return 32'h0;
    endfunction

    function automatic logic [31:0] word(logic [5:0] opc, logic [15:0] imm);
        return {opc, 4'h0, imm, 6'h00};
    endfunction

    assign imm_in1 = ext_model(ir_hold1, extend1);
    assign imm_in3 = ext_model(ir_hold3, extend3);

    immediate_sequencer dut1 (
        .clk(clk), .Reset_n(Reset_n), .IR_Valid(IR_Valid), .IR(IR),
        .IR_Ready(ir_ready1), .IR_Hold(ir_hold1), .Extend(extend1),
        .Imm_In(imm_in1), .Imm_Out(imm_out1), .Imm_Valid(imm_valid1),
        .Imm_Ready(Imm_Ready), .Abort(Abort), .Busy(busy1)
    );

    immediate_sequencer #(.IMM_SETTLE(3)) dut3 (
        .clk(clk), .Reset_n(Reset_n), .IR_Valid(IR_Valid), .IR(IR),
        .IR_Ready(ir_ready3), .IR_Hold(ir_hold3), .Extend(extend3),
        .Imm_In(imm_in3), .Imm_Out(imm_out3), .Imm_Valid(imm_valid3),
        .Imm_Ready(Imm_Ready), .Abort(Abort), .Busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [31:0] w);
        IR_Valid = 1'b1;
        IR       = w;
        tick();
        IR_Valid = 1'b0;
    endtask

    task automatic handshake1();
        Imm_Ready = 1'b1;
        tick();
        Imm_Ready = 1'b0;
        check("hs_valid", 32'(imm_valid1), 32'd0);
        check("hs_busy", 32'(busy1), 32'd0);
        check("hs_ready", 32'(ir_ready1), 32'd1);
        check("hs_extend", 32'(extend1), 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        tests_run    = 0;
        tests_failed = 0;
        Reset_n   = 1'b0;
        IR_Valid  = 1'b0;
        IR        = 32'h0;
        Imm_Ready = 1'b0;
        Abort     = 1'b0;

        #12;
        check("rst_ir_ready", 32'(ir_ready1), 32'd0);
        check("rst_ir_hold", ir_hold1, 32'd0);
        check("rst_extend", 32'(extend1), 32'd0);
        check("rst_imm_out", imm_out1, 32'd0);
        check("rst_imm_valid", 32'(imm_valid1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        Reset_n = 1'b1;
        tick();
        check("rel_ir_ready", 32'(ir_ready1), 32'd1);

        // Sign-extended single word, one-cycle latency
        send(word(6'h08, 16'hFFF0));
        check("sx_extend", 32'(extend1), 32'd1);
        check("sx_ir_ready", 32'(ir_ready1), 32'd0);
        check("sx_busy", 32'(busy1), 32'd1);
        check("sx_valid_early", 32'(imm_valid1), 32'd0);
        tick();
        check("sx_valid", 32'(imm_valid1), 32'd1);
        check("sx_imm", imm_out1, 32'hFFFFFFF0);
        handshake1();

        // Zero-extended ORI with consumer stalling five cycles
        send(word(6'h0D, 16'h8001));
        check("ori_extend", 32'(extend1), 32'd2);
        tick();
        check("ori_imm", imm_out1, 32'h00008001);
        held = imm_out1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_imm", imm_out1, held);
            check("stall_valid", 32'(imm_valid1), 32'd1);
            check("stall_ir_ready", 32'(ir_ready1), 32'd0);
            check("stall_hold", ir_hold1, word(6'h0D, 16'h8001));
        end
        handshake1();
        check("idle_keeps_imm", imm_out1, 32'h00008001);

        // Wide immediate; second opcode would sign-extend if not forced
        send(word(6'h0F, 16'h1234));
        check("wide1_extend", 32'(extend1), 32'd2);
        check("wide1_ir_ready", 32'(ir_ready1), 32'd0);
        tick();
        check("wwait_ir_ready", 32'(ir_ready1), 32'd1);
        check("wwait_busy", 32'(busy1), 32'd1);
        send(word(6'h08, 16'hABCD));
        check("wide2_extend", 32'(extend1), 32'd2);
        check("wide2_ir_ready", 32'(ir_ready1), 32'd0);
        tick();
        check("wide_valid", 32'(imm_valid1), 32'd1);
        check("wide_imm", imm_out1, 32'h1234ABCD);
        check("wide_out_ir_ready", 32'(ir_ready1), 32'd0);
        handshake1();

        // Abort in WIDE_WAIT drops the upper half
        send(word(6'h0F, 16'h1234));
        tick();
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        check("abort_busy", 32'(busy1), 32'd0);
        check("abort_ir_ready", 32'(ir_ready1), 32'd1);
        check("abort_extend", 32'(extend1), 32'd0);
        send(word(6'h08, 16'h0005));
        check("post_abort_extend", 32'(extend1), 32'd1);
        tick();
        check("post_abort_imm", imm_out1, 32'h00000005);
        handshake1();

        // Abort beats a simultaneous accept
        Abort    = 1'b1;
        IR_Valid = 1'b1;
        IR       = word(6'h08, 16'h0001);
        tick();
        Abort    = 1'b0;
        IR_Valid = 1'b0;
        check("abort_vs_accept_busy", 32'(busy1), 32'd0);
        check("abort_vs_accept_ext", 32'(extend1), 32'd0);

        // IMM_SETTLE=3 instance: latency and asynchronous reset mid-settle
        Reset_n = 1'b0;
        #2;
        Reset_n = 1'b1;
        tick();
        check("s3_ir_ready", 32'(ir_ready3), 32'd1);
        send(word(6'h0D, 16'h0042));
        tick();
        check("s3_valid_c1", 32'(imm_valid3), 32'd0);
        tick();
        check("s3_valid_c2", 32'(imm_valid3), 32'd0);
        tick();
        check("s3_valid_c3", 32'(imm_valid3), 32'd1);
        check("s3_imm", imm_out3, 32'h00000042);
        Imm_Ready = 1'b1;
        tick();
        Imm_Ready = 1'b0;

        send(word(6'h08, 16'h0007));
        tick();
        check("s3_mid_busy", 32'(busy3), 32'd1);
        #2;
        Reset_n = 1'b0;
        #1;
        check("s3_rst_ir_ready", 32'(ir_ready3), 32'd0);
        check("s3_rst_ir_hold", ir_hold3, 32'd0);
        check("s3_rst_extend", 32'(extend3), 32'd0);
        check("s3_rst_imm_out", imm_out3, 32'd0);
        check("s3_rst_valid", 32'(imm_valid3), 32'd0);
        check("s3_rst_busy", 32'(busy3), 32'd0);
        Reset_n = 1'b1;
        tick();
        check("s3_rel_ir_ready", 32'(ir_ready3), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("s3_no_stale_valid", 32'(imm_valid3), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
